opb_register_bank_simulink2ppc: RTL

Parametrised successor of the single simulink2ppc software register: a bank of C_NUM_CH user-to-processor registers readable over OPB. Each channel captures fabric data on a valid strobe, with per-channel fresh/overflow flags and capture counters. A snapshot mode holds the first value after software arms the channel. Sits on the OPB bus beside the other software registers; the user side is already in the OPB_Clk domain.

---
 rtl/opb_register_bank_simulink2ppc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/opb_register_bank_simulink2ppc.sv
// Bank of user-to-processor capture registers on the OPB bus.
// Each channel latches fabric data on its valid strobe and keeps fresh,
// overflow and 16-bit capture-count state. In snapshot mode a channel only
// captures while armed; software re-arms all channels through CONTROL.
// Word map: data[0..N-1], STATUS, CONTROL, counter[0..N-1].
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0108_0200,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108_02FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_DATA_WIDTH = 32,
    parameter int          C_MODE       = 0
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]          OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]        OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]          OPB_DBus,
    input  logic                             OPB_RNW,
    input  logic                             OPB_select,
    input  logic                             OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]          Sl_DBus,
    output logic                             Sl_xferAck,
    output logic                             Sl_errAck,
    output logic                             Sl_retry,
    output logic                             Sl_toutSup,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
    input  logic [C_NUM_CH-1:0]              user_valid
);

    localparam int AW = C_OPB_AWIDTH;
    localparam int DW = C_OPB_DWIDTH;
    localparam int N  = C_NUM_CH;
    localparam int W  = C_DATA_WIDTH;
    localparam logic [AW-1:0] BASE = AW'(C_BASEADDR);
    localparam logic [AW-1:0] HIGH = AW'(C_HIGHADDR);

    // Ascending bus vectors map onto descending locals so that numeric
    // value is preserved: bus bit 31 is the LSB.
    logic [AW-1:0] addr;
    logic [AW-1:0] offset;
    logic [AW-1:0] word;
    logic          hit;
    logic [DW-1:0] rd_word;

    logic          ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    // ctrl bit0 = re-arm all, bit1 = clear counters, bit2 = clear overflow
    logic [2:0]    ctrl_q, ctrl_d;
    logic [N-1:0]  rdclr_q, rdclr_d;

    logic [N-1:0][W-1:0] data_q, data_d;
    logic [N-1:0][15:0]  cnt_q, cnt_d;
    logic [N-1:0]        fresh_q, fresh_d;
    logic [N-1:0]        ovf_q, ovf_d;
    logic [N-1:0]        armed_q, armed_d;
    logic [N-1:0]        cap;

    logic unused_bits;

    assign addr   = OPB_ABus;
    assign offset = addr - BASE;
    assign word   = {2'b00, offset[AW-1:2]};
    // A new transfer is only accepted when no ack is in flight.
    assign hit    = OPB_select && (addr >= BASE) && (addr <= HIGH) && !ack_q;

    assign unused_bits = ^{OPB_seqAddr, offset[1:0], OPB_DBus[0:DW-4], OPB_BE[0:DW/8-2]};

    // Read multiplexer over the current register state.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N; i++) begin
            if (word == AW'(i)) rd_word = DW'(data_q[i]);
            if (word == AW'(N + 2 + i)) rd_word = DW'(cnt_q[i]);
        end
        if (word == AW'(N)) begin
            rd_word[N-1:0]  = fresh_q;
            rd_word[16 +: N] = ovf_q;
        end
    end

    // Bus decode: everything registered here takes effect in the ack cycle.
    always_comb begin
        ack_d   = hit;
        rdata_d = '0;
        ctrl_d  = '0;
        rdclr_d = '0;
        if (hit) begin
            if (OPB_RNW) begin
                rdata_d = rd_word;
                for (int i = 0; i < N; i++) begin
                    if (word == AW'(i)) rdclr_d[i] = 1'b1;
                end
            end else if (OPB_BE[DW/8-1] && (word == AW'(N + 1))) begin
                ctrl_d = {OPB_DBus[DW-3], OPB_DBus[DW-2], OPB_DBus[DW-1]};
            end
        end
    end

    // Per-channel capture; a read-clear in the same cycle suppresses overflow,
    // and a capture lands after any clear so it is never lost.
    always_comb begin
        cap     = '0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        fresh_d = fresh_q;
        ovf_d   = ovf_q;
        armed_d = armed_q;
        for (int i = 0; i < N; i++) begin
            cap[i]     = user_valid[i] && ((C_MODE == 0) || armed_q[i]);
            data_d[i]  = cap[i] ? user_data_in[i*W +: W] : data_q[i];
            fresh_d[i] = cap[i] | (fresh_q[i] & ~rdclr_q[i]);
            ovf_d[i]   = (cap[i] & fresh_q[i] & ~rdclr_q[i]) | (ovf_q[i] & ~ctrl_q[2]);
            cnt_d[i]   = (ctrl_q[1] ? 16'd0 : cnt_q[i]) + 16'(cap[i]);
            armed_d[i] = ctrl_q[0] | (armed_q[i] & ~(cap[i] && (C_MODE == 1)));
        end
    end

    // State registers; reset also drops any pending acknowledge.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            ctrl_q  <= '0;
            rdclr_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            fresh_q <= '0;
            ovf_q   <= '0;
            armed_q <= '1;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            rdclr_q <= rdclr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            fresh_q <= fresh_d;
            ovf_q   <= ovf_d;
            armed_q <= armed_d;
        end
    end

    // rdata_q is only non-zero during the ack cycle of a read.
    assign Sl_DBus    = rdata_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule
